// File: rtl/pingpong_bank_writer.sv
// -----------------------------------------------------------------------------
// pingpong_bank_writer
//
// Double-buffered frame collector. A write stream that never stalls fills one
// bank word by word. When a bank holds a complete frame it is marked full and
// the writer moves to the other bank. A small read FSM streams each full bank
// out through a valid/ready port, one word per cycle, and releases the bank
// once the last word has been accepted. Banks are written and read strictly
// alternately, so frames leave in the same order they arrived. Writes that
// arrive while the current write bank is still full are dropped and flagged.
//
// Ports
//   i_clock           single clock, rising edge
//   i_reset_n         asynchronous active-low reset
//   i_data  [WIDTH]   write word
//   i_valid           write strobe (no backpressure towards the writer)
//   o_data  [WIDTH]   readout word
//   o_valid           readout word valid
//   i_ready           downstream accepts the readout word
//   o_last            readout word is the final word of its frame
//   o_overflow        sticky: a write was dropped
//   i_clear_overflow  synchronous clear of o_overflow (a drop in the same
//                     cycle takes priority)
//
// Parameters
//   WIDTH      data word width
//   FRAME_LEN  words per frame; must be a power of two and at least 2, so the
//              write/read addresses wrap naturally at the end of a frame
//
// Read FSM states
//   state     | meaning
//   RD_IDLE   | waiting for full[rd_bank]; output register empty
//   RD_STREAM | moving bank[rd_bank] through the output register
// -----------------------------------------------------------------------------
module pingpong_bank_writer #(
  parameter int WIDTH     = 16,
  parameter int FRAME_LEN = 1024
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_last,
  output logic             o_overflow,
  input  logic             i_clear_overflow
);

  localparam int            AW        = $clog2(FRAME_LEN);
  localparam logic [AW-1:0] LAST_ADDR = AW'(FRAME_LEN - 1);

  typedef enum logic {
    RD_IDLE   = 1'b0,
    RD_STREAM = 1'b1
  } rd_state_e;

  rd_state_e rd_state_q, rd_state_d;

  // Bank storage; intentionally not reset.
  logic [WIDTH-1:0] mem_q [2][FRAME_LEN];

  logic [1:0]       full_q, full_d;
  logic             wr_bank_q, wr_bank_d;
  logic [AW-1:0]    wr_addr_q, wr_addr_d;
  logic             rd_bank_q, rd_bank_d;
  logic [AW-1:0]    rd_addr_q, rd_addr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             ovf_q, ovf_d;

  logic wr_en;
  logic wr_drop;
  logic wr_wrap;
  logic rd_load;
  logic rd_release;

  // ---------------------------------------------------------------------------
  // Write side. The full flag is the registered value, so a write landing on
  // the same edge that the reader releases the bank is still a drop.
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_en     = i_valid && !full_q[wr_bank_q];
    wr_drop   = i_valid &&  full_q[wr_bank_q];
    wr_wrap   = wr_en && (wr_addr_q == LAST_ADDR);
    wr_addr_d = wr_addr_q;
    wr_bank_d = wr_bank_q;
    if (wr_en) begin
      wr_addr_d = wr_addr_q + AW'(1);
      if (wr_wrap) begin
        wr_bank_d = ~wr_bank_q;
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (wr_en) begin
      mem_q[wr_bank_q][wr_addr_q] <= i_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Full flags and overflow. A release and a frame completion can coincide;
  // they always target different banks (one must be full, the other not).
  // ---------------------------------------------------------------------------
  always_comb begin
    full_d = full_q;
    if (rd_release) begin
      full_d[rd_bank_q] = 1'b0;
    end
    if (wr_wrap) begin
      full_d[wr_bank_q] = 1'b1;
    end

    if (wr_drop) begin
      ovf_d = 1'b1;
    end else if (i_clear_overflow) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Read FSM. The output register is refilled whenever it is empty or its
  // word is being accepted, giving one word per cycle under i_ready=1. Once
  // the last word sits in the register no further fetch is made; its
  // acceptance releases the bank and returns to idle.
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_state_d = rd_state_q;
    rd_bank_d  = rd_bank_q;
    rd_addr_d  = rd_addr_q;
    data_d     = data_q;
    valid_d    = valid_q;
    last_d     = last_q;
    rd_load    = 1'b0;
    rd_release = 1'b0;

    case (rd_state_q)
      RD_IDLE: begin
        if (full_q[rd_bank_q]) begin
          rd_state_d = RD_STREAM;
          rd_addr_d  = '0;
        end
      end

      RD_STREAM: begin
        if (valid_q && i_ready) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          if (last_q) begin
            rd_release = 1'b1;
            rd_bank_d  = ~rd_bank_q;
            rd_state_d = RD_IDLE;
          end
        end

        rd_load = !last_q && (!valid_q || i_ready);
        if (rd_load) begin
          data_d    = mem_q[rd_bank_q][rd_addr_q];
          valid_d   = 1'b1;
          last_d    = (rd_addr_q == LAST_ADDR);
          rd_addr_d = rd_addr_q + AW'(1);
        end
      end

      default: begin
        rd_state_d = RD_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rd_state_q <= RD_IDLE;
      full_q     <= '0;
      wr_bank_q  <= 1'b0;
      wr_addr_q  <= '0;
      rd_bank_q  <= 1'b0;
      rd_addr_q  <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      full_q     <= full_d;
      wr_bank_q  <= wr_bank_d;
      wr_addr_q  <= wr_addr_d;
      rd_bank_q  <= rd_bank_d;
      rd_addr_q  <= rd_addr_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      ovf_q      <= ovf_d;
    end
  end

  assign o_data     = data_q;
  assign o_valid    = valid_q;
  assign o_last     = last_q;
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_pingpong_bank_writer.sv
module tb_pingpong_bank_writer;

  localparam int WIDTH     = 16;
  localparam int FRAME_LEN = 4;

  logic             i_clock          = 1'b0;
  logic             i_reset_n        = 1'b0;
  logic [WIDTH-1:0] i_data           = '0;
  logic             i_valid          = 1'b0;
  logic             i_ready          = 1'b0;
  logic             i_clear_overflow = 1'b0;
  logic [WIDTH-1:0] o_data;
  logic             o_valid;
  logic             o_last;
  logic             o_overflow;

  int n_checks = 0;
  int n_errors = 0;

  // Accepted readout words as {last, data}.
  logic [WIDTH:0] got[$];

  logic             stall_q = 1'b0;
  logic [WIDTH-1:0] stall_data = '0;
  logic             stall_last = 1'b0;

  always #5 i_clock = ~i_clock;

  pingpong_bank_writer #(
    .WIDTH     (WIDTH),
    .FRAME_LEN (FRAME_LEN)
  ) dut (
    .i_clock          (i_clock),
    .i_reset_n        (i_reset_n),
    .i_data           (i_data),
    .i_valid          (i_valid),
    .o_data           (o_data),
    .o_valid          (o_valid),
    .i_ready          (i_ready),
    .o_last           (o_last),
    .o_overflow       (o_overflow),
    .i_clear_overflow (i_clear_overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are observed on
  // the falling edge, which is also where acceptance for the next edge is seen.
  always @(negedge i_clock) begin
    if (!i_reset_n) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        check("hold_valid", o_valid, 1);
        check("hold_data", o_data, stall_data);
        check("hold_last", o_last, stall_last);
      end
      stall_q    = o_valid && !i_ready;
      stall_data = o_data;
      stall_last = o_last;
      if (o_valid && i_ready) got.push_back({o_last, o_data});
    end
  end

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  // Four consecutive words base..base+3, optionally with an idle cycle after each.
  task automatic write_frame(input logic [WIDTH-1:0] base, input bit gap);
    for (int i = 0; i < FRAME_LEN; i++) begin
      i_valid = 1'b1;
      i_data  = base + WIDTH'(i);
      tick();
      i_valid = 1'b0;
      if (gap) tick();
    end
  endtask

  task automatic wait_words(input int n, input int budget);
    int c = 0;
    while (got.size() < n && c < budget) begin
      tick();
      c++;
    end
    repeat (8) tick();
    check("word_count", got.size(), n);
  endtask

  task automatic expect_seq(input string tag, input logic [WIDTH-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      if (i < got.size()) begin
        check({tag, "_data"}, got[i][WIDTH-1:0], base + WIDTH'(i));
        check({tag, "_last"}, got[i][WIDTH], (i % FRAME_LEN) == FRAME_LEN - 1);
      end else begin
        check({tag, "_missing"}, got.size(), i + 1);
      end
    end
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_valid", o_valid, 0);
    check("rst_last", o_last, 0);
    check("rst_ovf", o_overflow, 0);
    check("rst_data", o_data, 0);
    tick();
    i_reset_n = 1'b1;
    tick();

    // Single frame: exact latency and ordering
    got.delete();
    i_ready = 1'b1;
    write_frame(16'h0010, 1'b0);
    check("lat_e0_valid", o_valid, 0);
    tick();
    check("lat_e1_valid", o_valid, 0);
    tick();
    check("lat_e2_valid", o_valid, 1);
    check("w0_data", o_data, 16'h0010);
    check("w0_last", o_last, 0);
    tick();
    check("w1_data", o_data, 16'h0011);
    check("w1_valid", o_valid, 1);
    check("w1_last", o_last, 0);
    tick();
    check("w2_data", o_data, 16'h0012);
    check("w2_last", o_last, 0);
    tick();
    check("w3_data", o_data, 16'h0013);
    check("w3_last", o_last, 1);
    tick();
    check("post_valid", o_valid, 0);
    wait_words(4, 20);
    expect_seq("single", 16'h0010, 4);

    // Backpressure: i_ready toggles 1,0,1,0 while the frame streams
    got.delete();
    write_frame(16'h0010, 1'b0);
    for (int k = 0; k < 16; k++) begin
      i_ready = (k % 2) == 0;
      tick();
    end
    i_ready = 1'b1;
    wait_words(4, 20);
    expect_seq("bp", 16'h0010, 4);

    // Overflow: 12 words with no reader progress, last four dropped
    got.delete();
    i_ready = 1'b0;
    check("ovf_before", o_overflow, 0);
    write_frame(16'h0020, 1'b0);
    write_frame(16'h0024, 1'b0);
    write_frame(16'h0028, 1'b0);
    tick();
    check("ovf_set", o_overflow, 1);
    check("ovf_head_valid", o_valid, 1);
    check("ovf_head_data", o_data, 16'h0020);
    i_ready = 1'b1;
    wait_words(8, 40);
    expect_seq("ovf", 16'h0020, 8);
    check("ovf_sticky", o_overflow, 1);

    // Overflow clear versus a drop in the same cycle
    got.delete();
    i_clear_overflow = 1'b1;
    tick();
    i_clear_overflow = 1'b0;
    check("clr_plain", o_overflow, 0);
    i_ready = 1'b0;
    write_frame(16'h0050, 1'b0);
    write_frame(16'h0054, 1'b0);
    check("both_full_no_ovf", o_overflow, 0);
    i_valid          = 1'b1;
    i_data           = 16'h0058;
    i_clear_overflow = 1'b1;
    tick();
    i_valid          = 1'b0;
    i_clear_overflow = 1'b0;
    check("clr_collision", o_overflow, 1);
    i_clear_overflow = 1'b1;
    tick();
    i_clear_overflow = 1'b0;
    check("clr_after", o_overflow, 0);
    i_ready = 1'b1;
    wait_words(8, 40);
    expect_seq("clr", 16'h0050, 8);

    // Ping-pong continuity over four frames. The strobe is on every other
    // cycle: the reader spends two turnaround cycles per frame (release and
    // idle), so an unbroken one-word-per-cycle stream would outrun it.
    got.delete();
    write_frame(16'h0000, 1'b1);
    write_frame(16'h0004, 1'b1);
    write_frame(16'h0008, 1'b1);
    write_frame(16'h000C, 1'b1);
    wait_words(16, 60);
    expect_seq("pp", 16'h0000, 16);
    check("pp_no_ovf", o_overflow, 0);

    // Mid-frame reset after two words have been accepted
    got.delete();
    write_frame(16'h0040, 1'b0);
    begin
      int c = 0;
      while (got.size() < 2 && c < 20) begin
        tick();
        c++;
      end
    end
    check("mid_two_words", got.size(), 2);
    i_reset_n = 1'b0;
    #1;
    check("mid_rst_valid", o_valid, 0);
    check("mid_rst_last", o_last, 0);
    check("mid_rst_data", o_data, 0);
    tick();
    tick();
    check("mid_rst_hold_valid", o_valid, 0);
    i_reset_n = 1'b1;
    tick();
    got.delete();
    write_frame(16'h0030, 1'b0);
    wait_words(4, 20);
    expect_seq("after_rst", 16'h0030, 4);
    check("after_rst_ovf", o_overflow, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
